// File: rtl/stage_seq_pkg.sv
// Shared constants for the stage sequencer: legacy stage names, default stage
// count and the dwell-counter range.
package stage_seq_pkg;

  localparam int STAGE_FETCH      = 0;
  localparam int STAGE_DECODE     = 1;
  localparam int STAGE_READ       = 2;
  localparam int STAGE_EXECUTE    = 3;
  localparam int STAGE_MEMORY     = 4;
  localparam int STAGE_WRITE_BACK = 5;

  localparam int DEFAULT_NUM_STAGES = 6;
  localparam int MAX_DWELL          = 15;
  localparam int DWELL_W            = 4;   // holds 0..MAX_DWELL

endpackage

// File: rtl/stage_sequencer_next_sel.sv
// stage_next_sel: combinational next-stage search.
// Returns the lowest enabled stage strictly above the current one. If there is
// none, it wraps to stage 0. A run of disabled stages is skipped in a single step.
//   cur_i  in  NUM_STAGES  one-hot current stage
//   en_i   in  NUM_STAGES  per-stage enable (bit 0 never matters: stage 0 is the wrap target)
//   nxt_o  out NUM_STAGES  one-hot next stage
module stage_next_sel import stage_seq_pkg::*; #(
  parameter int NUM_STAGES = DEFAULT_NUM_STAGES
) (
  input  logic [NUM_STAGES-1:0] cur_i,
  input  logic [NUM_STAGES-1:0] en_i,
  output logic [NUM_STAGES-1:0] nxt_o
);

  logic seen, found;

  always_comb begin
    nxt_o = '0;
    seen  = 1'b0;
    found = 1'b0;
    // Scan upward; only stages after the current one are candidates.
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (seen && en_i[i] && !found) begin
        nxt_o[i] = 1'b1;
        found    = 1'b1;
      end
      if (cur_i[i]) seen = 1'b1;
    end
    if (!found) nxt_o[0] = 1'b1;
  end

endmodule

// File: rtl/stage_sequencer.sv
// stage_sequencer: parametrised one-hot stage sequencer for the multi-cycle core.
// Moves through NUM_STAGES stages and skips disabled stages. It enforces a
// minimum dwell of MIN_DWELL cycles per stage. It supports flush to stage 0 and a
// global hold, and it raises stage-entry and round-complete strobes.
// Optional perf counters are built in when STAGE_SEQ_PERF_EN is defined.
// Without that macro, round_count and stall_count are tied to zero.
//   clk, reset_n   clock, asynchronous active-low reset
//   stage_enabled  per-stage enable (bit 0 forced on)
//   stage_done     per-stage done (only the active stage's bit is looked at)
//   hold / flush   block advance / force return to stage 0 (flush wins)
//   stage_active   one-hot current stage;  stage_index  its binary index
//   stage_enter    first cycle of a residency; round_done  advance into stage 0
//   round_count, stall_count  perf counters
module stage_sequencer import stage_seq_pkg::*; #(
  parameter  int NUM_STAGES = DEFAULT_NUM_STAGES,
  parameter  int MIN_DWELL  = 1,
  localparam int IDX_W      = $clog2(NUM_STAGES)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_STAGES-1:0] stage_enabled,
  input  logic [NUM_STAGES-1:0] stage_done,
  input  logic                  hold,
  input  logic                  flush,
  output logic [NUM_STAGES-1:0] stage_active,
  output logic [IDX_W-1:0]      stage_index,
  output logic                  stage_enter,
  output logic                  round_done,
  output logic [31:0]           round_count,
  output logic [31:0]           stall_count
);

  localparam logic [DWELL_W-1:0] MIN_DW = DWELL_W'(MIN_DWELL);

  logic [NUM_STAGES-1:0] stage_active_q, stage_active_d;
  logic [IDX_W-1:0]      stage_index_q, stage_index_d;
  logic [DWELL_W-1:0]    dwell_q;
  logic                  stage_enter_q, round_done_q;
  logic                  cur_done, advance;

  stage_next_sel #(.NUM_STAGES(NUM_STAGES)) u_next_sel (
    .cur_i (stage_active_q),
    .en_i  (stage_enabled),
    .nxt_o (stage_active_d)
  );

  assign cur_done = |(stage_done & stage_active_q);
  assign advance  = cur_done && (dwell_q == MIN_DW) && !hold;

  always_comb begin
    stage_index_d = '0;
    for (int i = 0; i < NUM_STAGES; i++)
      if (stage_active_d[i]) stage_index_d = IDX_W'(i);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stage_active_q <= NUM_STAGES'(1);
      stage_index_q  <= '0;
      dwell_q        <= '0;
      stage_enter_q  <= 1'b1;
      round_done_q   <= 1'b0;
    end else begin
      stage_enter_q <= 1'b0;
      round_done_q  <= 1'b0;
      if (flush) begin
        // A flush re-enters stage 0 even if the sequencer is already there.
        stage_active_q <= NUM_STAGES'(1);
        stage_index_q  <= '0;
        dwell_q        <= '0;
        stage_enter_q  <= 1'b1;
      end else if (advance) begin
        stage_active_q <= stage_active_d;
        stage_index_q  <= stage_index_d;
        dwell_q        <= '0;
        stage_enter_q  <= 1'b1;
        round_done_q   <= stage_active_d[0];
      end else if (dwell_q != MIN_DW) begin
        // Hold does not stop the dwell counter; it saturates at MIN_DWELL.
        dwell_q <= dwell_q + 1'b1;
      end
    end
  end

  assign stage_active = stage_active_q;
  assign stage_index  = stage_index_q;
  assign stage_enter  = stage_enter_q;
  assign round_done   = round_done_q;

`ifdef STAGE_SEQ_PERF_EN
  logic [31:0] round_cnt_q, stall_cnt_q;

  // round_count moves in the same cycle that round_done rises.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      round_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (!flush && advance && stage_active_d[0]) round_cnt_q <= round_cnt_q + 32'd1;
      if (!cur_done && !flush)                    stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign round_count = round_cnt_q;
  assign stall_count = stall_cnt_q;
`else
  assign round_count = 32'd0;
  assign stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer: three instances (MIN_DWELL 1, 3, 0) share the same stimulus.
module tb_stage_sequencer;

  logic       clk, reset_n, hold, flush;
  logic [5:0] en, done;

  logic [5:0]  act1, act3, act0;
  logic [2:0]  idx1, idx3, idx0;
  logic        ent1, ent3, ent0, rd1, rd3, rd0;
  logic [31:0] rc1, rc3, rc0, sc1, sc3, sc0;

  int n_chk = 0;
  int n_fail = 0;

`ifdef STAGE_SEQ_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  stage_sequencer #(.NUM_STAGES(6), .MIN_DWELL(1)) u_d1 (
    .clk(clk), .reset_n(reset_n), .stage_enabled(en), .stage_done(done), .hold(hold), .flush(flush),
    .stage_active(act1), .stage_index(idx1), .stage_enter(ent1), .round_done(rd1),
    .round_count(rc1), .stall_count(sc1));

  stage_sequencer #(.NUM_STAGES(6), .MIN_DWELL(3)) u_d3 (
    .clk(clk), .reset_n(reset_n), .stage_enabled(en), .stage_done(done), .hold(hold), .flush(flush),
    .stage_active(act3), .stage_index(idx3), .stage_enter(ent3), .round_done(rd3),
    .round_count(rc3), .stall_count(sc3));

  stage_sequencer #(.NUM_STAGES(6), .MIN_DWELL(0)) u_d0 (
    .clk(clk), .reset_n(reset_n), .stage_enabled(en), .stage_done(done), .hold(hold), .flush(flush),
    .stage_active(act0), .stage_index(idx0), .stage_enter(ent0), .round_done(rd0),
    .round_count(rc0), .stall_count(sc0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; hold = 1'b0; flush = 1'b0;
    en = 6'h3F; done = 6'h3F;
    #12;
    chk("rst_act", 32'(act1), 32'h1);
    chk("rst_idx", 32'(idx1), 0);
    chk("rst_ent", 32'(ent1), 1);
    chk("rst_rd",  32'(rd1), 0);
    chk("rst_rc",  rc1, 0);
    chk("rst_sc",  sc1, 0);
    chk("rst_idx3", 32'(idx3), 0);
    chk("rst_idx0", 32'(idx0), 0);
    chk("rst_cnt30", rc3 | sc3 | rc0 | sc0, 0);
    reset_n = 1'b1;

    // All stages enabled and always done.
    for (int k = 1; k <= 24; k++) begin
      step();
      chk("t1_idx1", 32'(idx1), (k/2)%6);
      chk("t1_act1", 32'(act1), 32'(1) << ((k/2)%6));
      chk("t1_ent1", 32'(ent1), 32'(k%2 == 0));
      chk("t1_rd1",  32'(rd1),  32'(k == 12 || k == 24));
      chk("t1_idx3", 32'(idx3), (k/4)%6);
      chk("t1_ent3", 32'(ent3), 32'(k%4 == 0));
      chk("t1_rd3",  32'(rd3),  32'(k == 24));
      chk("t1_idx0", 32'(idx0), k%6);
      chk("t1_ent0", 32'(ent0), 1);
      chk("t1_rd0",  32'(rd0),  32'(k%6 == 0));
    end

    // Only stages 0 and 5 are enabled.
    en = 6'b100001;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("t2_idx1", 32'(idx1), ((k/2)%2) ? 5 : 0);
      chk("t2_idx3", 32'(idx3), ((k/4)%2) ? 5 : 0);
      chk("t2_idx0", 32'(idx0), (k%2) ? 5 : 0);
      chk("t2_mid",  32'((act1 | act3 | act0) & 6'b011110), 0);
      chk("t2_rd1",  32'(rd1), 32'(k == 4 || k == 8));
    end

    // Stage 3 done is held low for 7 cycles.
    en = 6'h3F;
    for (int k = 1; k <= 6; k++) step();
    chk("t3_at3", 32'(idx1), 3);
    chk("t3_ent", 32'(ent1), 1);
    done = 6'b110111;
    for (int k = 1; k <= 7; k++) begin
      step();
      chk("t3_stay", 32'(idx1), 3);
    end
    done = 6'h3F;
    step();
    chk("t3_adv", 32'(idx1), 4);
    chk("t3_ent4", 32'(ent1), 1);
    chk("t3_stall", sc1, PERF ? 32'd7 : 32'd0);
    chk("t3_rounds", rc1, PERF ? 32'd4 : 32'd0);

    // A flush with hold active, a re-entry flush in stage 0, then hold alone.
    hold = 1'b1; flush = 1'b1;
    step();
    chk("t4_act", 32'(act1), 32'h1);
    chk("t4_ent", 32'(ent1), 1);
    chk("t4_rd",  32'(rd1), 0);
    step();
    chk("t4_reent_idx", 32'(idx1), 0);
    chk("t4_reent_ent", 32'(ent1), 1);
    flush = 1'b0;
    step();
    chk("t4_hold_a", 32'(idx1), 0);
    chk("t4_hold_ent", 32'(ent1), 0);
    step();
    chk("t4_hold_b", 32'(idx1), 0);
    hold = 1'b0;
    step();
    chk("t4_rel_idx", 32'(idx1), 1);
    chk("t4_rel_ent", 32'(ent1), 1);
    chk("t4_rounds", rc1, PERF ? 32'd4 : 32'd0);

    // Assert reset asynchronously in the middle of a stage.
    step();
    chk("t6_pre", 32'(idx1), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_act", 32'(act1), 32'h1);
    chk("t6_idx", 32'(idx1), 0);
    chk("t6_ent", 32'(ent1), 1);
    chk("t6_rd",  32'(rd1), 0);
    chk("t6_cnt", rc1 | sc1, 0);
    #2 reset_n = 1'b1;
    #1;
    chk("t6_rel_idx", 32'(idx1), 0);
    step();
    chk("t6_s0", 32'(idx1), 0);
    chk("t6_s0_ent", 32'(ent1), 0);
    step();
    chk("t6_s1", 32'(idx1), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
